// File: rtl/dcache_ram_pw_if.sv
// Access bus of the data-cache line store: index, write data/enables,
// invalidate request, registered read data and sweep-busy indication.
interface dcache_ram_pw_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 16,
  parameter int WORDS  = 5,
  parameter int STAT_W = 2
);
  localparam int LINE_W = WORDS * WORD_W;

  logic [ADDR_W-1:0]        i_addr;
  logic [LINE_W+STAT_W-1:0] i_data;
  logic [WORDS-1:0]         i_we_data;
  logic                     i_we_stat;
  logic                     i_inval;
  logic [LINE_W+STAT_W-1:0] o_data;
  logic                     o_busy;

  // Cache controller side: drives requests, receives read data.
  modport master (
    output i_addr, i_data, i_we_data, i_we_stat, i_inval,
    input  o_data, o_busy
  );

  // Line store side.
  modport slave (
    input  i_addr, i_data, i_we_data, i_we_stat, i_inval,
    output o_data, o_busy
  );
endinterface

// File: rtl/dcache_ram_pw.sv
// Data-cache line store: DEPTH lines of LINE_W data bits plus STAT_W status
// bits. Per-word data write enables, separate status write enable,
// write-first registered read. Status is cleared by a one-entry-per-cycle
// sweep that runs after reset and on an invalidate request; array writes
// are blocked while the sweep runs.
module dcache_ram_pw #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 16,
  parameter int WORDS  = 5,
  parameter int STAT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  dcache_ram_pw_if.slave   bus
);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LINE_W = WORDS * WORD_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              w_busy;

  logic [LINE_W-1:0] r_mem  [DEPTH];
  logic [STAT_W-1:0] r_stat [DEPTH];

  logic                     w_idle;
  logic [WORDS-1:0]         w_we_data;
  logic                     w_we_stat;
  logic [LINE_W-1:0]        w_rd_line;
  logic [STAT_W-1:0]        w_rd_stat;
  logic [LINE_W+STAT_W-1:0] r_data;

  // Writes only land in IDLE and never on an edge where reset is held,
  // so nothing can slip in behind the sweep pointer.
  assign w_idle    = (r_state == IDLE) && i_rst_n;
  assign w_we_data = w_idle ? bus.i_we_data : {WORDS{1'b0}};
  assign w_we_stat = w_idle && bus.i_we_stat;

  // Sweep FSM state register; reset restarts the sweep at index 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= SWEEP;
      r_cnt   <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sweep FSM next state: walk every index once, or start a new sweep on invalidate.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    case (r_state)
      SWEEP: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = SWEEP;
        end
      end
      IDLE: begin
        if (bus.i_inval) begin
          w_state_nxt = SWEEP;
          w_cnt_nxt   = {ADDR_W{1'b0}};
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_busy      = 1'b1;
        w_state_nxt = SWEEP;
        w_cnt_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign bus.o_busy = w_busy;

  // Data array: per-word byte-lane style writes, never touched by reset.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (w_we_data[k]) begin
        r_mem[bus.i_addr][k*WORD_W +: WORD_W] <= bus.i_data[STAT_W + k*WORD_W +: WORD_W];
      end
    end
  end

  // Status array: single write port shared between the sweep and normal writes.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (r_state == SWEEP) begin
        r_stat[r_cnt] <= {STAT_W{1'b0}};
      end else if (w_we_stat) begin
        r_stat[bus.i_addr] <= bus.i_data[STAT_W-1:0];
      end
    end
  end

  // Write-first read mux: written words/status take the incoming value.
  always_comb begin
    w_rd_line = r_mem[bus.i_addr];
    w_rd_stat = {STAT_W{1'b0}};
    for (int k = 0; k < WORDS; k++) begin
      if (w_we_data[k]) begin
        w_rd_line[k*WORD_W +: WORD_W] = bus.i_data[STAT_W + k*WORD_W +: WORD_W];
      end else begin
        w_rd_line[k*WORD_W +: WORD_W] = r_mem[bus.i_addr][k*WORD_W +: WORD_W];
      end
    end
    if (r_state == SWEEP) begin
      w_rd_stat = {STAT_W{1'b0}};
    end else if (w_we_stat) begin
      w_rd_stat = bus.i_data[STAT_W-1:0];
    end else begin
      w_rd_stat = r_stat[bus.i_addr];
    end
  end

  // Registered read port, refreshed every edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_data <= {(LINE_W+STAT_W){1'b0}};
    end else begin
      r_data <= {w_rd_line, w_rd_stat};
    end
  end

  assign bus.o_data = r_data;

endmodule

// File: tb/tb_dcache_ram_pw.sv
// Directed self-checking bench for dcache_ram_pw: default geometry plus a
// small-depth / wide-line variant.
module tb_dcache_ram_pw;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_ram_pw_if #(.ADDR_W(5), .WORD_W(16), .WORDS(5), .STAT_W(2)) if1 ();
  dcache_ram_pw_if #(.ADDR_W(3), .WORD_W(16), .WORDS(8), .STAT_W(3)) if2 ();

  dcache_ram_pw #(.ADDR_W(5), .WORD_W(16), .WORDS(5), .STAT_W(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  dcache_ram_pw #(.ADDR_W(3), .WORD_W(16), .WORDS(8), .STAT_W(3)) dut2 (
    .i_clk   (clk),
    .i_rst_n (rst2_n),
    .bus     (if2)
  );

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] exp_line(input int i);
    logic [15:0] w;
    w = 16'hC000 | 16'(i);
    return {w, w ^ 16'h0101, w, w ^ 16'h1010, w};
  endfunction

  task automatic count_busy1(output int n);
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (!if1.o_busy) break;
    end
  endtask

  task automatic count_busy2(output int n);
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (!if2.o_busy) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [81:0]  e1;
    logic [130:0] e2;

    if1.i_addr = 5'd0;  if1.i_data = 82'd0;  if1.i_we_data = 5'd0;
    if1.i_we_stat = 1'b0; if1.i_inval = 1'b0;
    if2.i_addr = 3'd0;  if2.i_data = 131'd0; if2.i_we_data = 8'd0;
    if2.i_we_stat = 1'b0; if2.i_inval = 1'b0;

    // Reset and the power-up sweep
    repeat (3) step();
    chk("rst_odata", 160'(if1.o_data), 160'd0);
    chk("rst_busy", 160'(if1.o_busy), 160'd1);
    rst_n = 1'b1;
    count_busy1(n);
    chk("rst_sweep_len", 160'(n), 160'd32);
    for (int i = 0; i < 32; i++) begin
      if1.i_addr = 5'(i);
      step();
      chk("rst_stat", 160'(if1.o_data[1:0]), 160'd0);
    end

    // Full line write, write-first read, then plain read-back
    if1.i_addr = 5'd7;
    if1.i_data = {80'h123456789ABCDEF01234, 2'b11};
    if1.i_we_data = 5'b11111;
    if1.i_we_stat = 1'b1;
    step();
    chk("full_wf", 160'(if1.o_data), 160'({80'h123456789ABCDEF01234, 2'b11}));
    if1.i_we_data = 5'b00000;
    if1.i_we_stat = 1'b0;
    if1.i_data = 82'd0;
    step();
    chk("full_rd", 160'(if1.o_data), 160'({80'h123456789ABCDEF01234, 2'b11}));

    // Partial word write keeps other words and status
    if1.i_data = {64'hFFFF_FFFF_FFFF_FFFF, 16'hBEEF, 2'b00};
    if1.i_we_data = 5'b00001;
    step();
    chk("part_wf", 160'(if1.o_data), 160'({80'h123456789ABCDEF0BEEF, 2'b11}));
    if1.i_we_data = 5'b00000;
    step();
    chk("part_rd", 160'(if1.o_data), 160'({80'h123456789ABCDEF0BEEF, 2'b11}));

    // Fill all entries with status 11
    for (int i = 0; i < 32; i++) begin
      if1.i_addr = 5'(i);
      if1.i_data = {exp_line(i), 2'b11};
      if1.i_we_data = 5'b11111;
      if1.i_we_stat = 1'b1;
      step();
    end
    if1.i_we_data = 5'b00000;
    if1.i_we_stat = 1'b0;
    if1.i_addr = 5'd3;
    step();
    chk("fill_rd3", 160'(if1.o_data), 160'({exp_line(3), 2'b11}));

    // Invalidate sweep with a dropped write at sweep cycle 10
    if1.i_inval = 1'b1;
    step();
    if1.i_inval = 1'b0;
    chk("inv_busy", 160'(if1.o_busy), 160'd1);
    n = 0;
    while (n < 100) begin
      if (n == 10) begin
        if1.i_addr = 5'd4;
        if1.i_data = {82{1'b1}};
        if1.i_we_data = 5'b11111;
        if1.i_we_stat = 1'b1;
      end else begin
        if1.i_addr = 5'd9;
        if1.i_data = 82'd0;
        if1.i_we_data = 5'b00000;
        if1.i_we_stat = 1'b0;
      end
      step();
      n++;
      if (n == 5) chk("inv_rd_sweep", 160'(if1.o_data), 160'({exp_line(9), 2'b00}));
      if (!if1.o_busy) break;
    end
    if1.i_we_data = 5'b00000;
    if1.i_we_stat = 1'b0;
    chk("inv_sweep_len", 160'(n), 160'd32);
    for (int i = 0; i < 32; i++) begin
      if1.i_addr = 5'(i);
      step();
      chk("inv_rd", 160'(if1.o_data), 160'({exp_line(i), 2'b00}));
    end

    // Writes work again after the sweep
    if1.i_addr = 5'd4;
    if1.i_data = {80'h0, 2'b01};
    if1.i_we_stat = 1'b1;
    step();
    if1.i_we_stat = 1'b0;
    step();
    chk("post_inv_stat", 160'(if1.o_data), 160'({exp_line(4), 2'b01}));

    // Reset in the middle of a sweep restarts it
    if1.i_inval = 1'b1;
    step();
    if1.i_inval = 1'b0;
    repeat (20) step();
    chk("mid_busy_pre", 160'(if1.o_busy), 160'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_busy", 160'(if1.o_busy), 160'd1);
    chk("mid_rst_odata", 160'(if1.o_data), 160'd0);
    rst_n = 1'b1;
    count_busy1(n);
    chk("mid_sweep_len", 160'(n), 160'd32);

    // Variant geometry: 8 entries, 8 words, 3 status bits
    step();
    rst2_n = 1'b1;
    count_busy2(n);
    chk("v2_sweep_len", 160'(n), 160'd8);
    if2.i_addr = 3'd2;
    if2.i_data = {128'd0, 3'b101};
    if2.i_we_data = 8'hFF;
    if2.i_we_stat = 1'b1;
    step();
    if2.i_data = {131{1'b1}};
    if2.i_we_data = 8'h80;
    if2.i_we_stat = 1'b0;
    step();
    e2 = '0;
    e2[130:115] = 16'hFFFF;
    e2[2:0] = 3'b101;
    chk("v2_word7_wf", 160'(if2.o_data), 160'(e2));
    if2.i_we_data = 8'h00;
    if2.i_data = 131'd0;
    step();
    chk("v2_word7_rd", 160'(if2.o_data), 160'(e2));

    e1 = {exp_line(0), 2'b00};
    if1.i_addr = 5'd0;
    step();
    chk("final_rd0", 160'(if1.o_data), 160'(e1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
